// File: rtl/imuldiv_div_share_arbiter_pkg.sv
// Purpose: shared encodings for the two-port divider share arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imuldiv_div_share_arbiter_pkg;

    // Arbiter sequencing states; one divide is in flight at a time.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Owner / last-grant encoding.
    localparam logic OWNER_REQ0 = 1'b0;
    localparam logic OWNER_REQ1 = 1'b1;

    // Divider function encoding carried on *_msg_fn.
    localparam logic FN_DIV  = 1'b0;
    localparam logic FN_DIVU = 1'b1;

endpackage

// File: rtl/imuldiv_rr_arb2.sv
// Purpose: combinational 2-way round-robin grant (one-hot), favouring the
//          requester that did not win last time when both are valid.
// Latency: 0 cycles; backpressure: none, pure function of its inputs.
// Ports: req0_val/req1_val request bits, last_grant pointer, grant[1:0] one-hot.
module imuldiv_rr_arb2
    import imuldiv_div_share_arbiter_pkg::*;
(
    input  logic       req0_val,
    input  logic       req1_val,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req0_val && req1_val) begin
            // Tie: hand the grant to whoever did not win last.
            grant = (last_grant == OWNER_REQ1) ? 2'b01 : 2'b10;
        end else if (req0_val) begin
            grant = 2'b01;
        end else if (req1_val) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/imuldiv_div_share_arbiter.sv
// Purpose: shares one iterative divider between two val/rdy requesters,
//          round-robin, one transaction in flight, result returned to owner.
// Latency: accept->divreq_val 1 cycle; divresp_val->resp val 1 cycle; a stalled
//          owner response or divider handshake holds the FSM (and the other port).
// Ports: req0/req1 request + resp0/resp1 response channels, divreq/divresp
//        divider channels, busy = not idle.
module imuldiv_div_share_arbiter
    import imuldiv_div_share_arbiter_pkg::*;
#(
    parameter int   DATA_W    = 32,
    parameter logic INIT_LAST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_msg_fn,
    input  logic [DATA_W-1:0]     req0_msg_a,
    input  logic [DATA_W-1:0]     req0_msg_b,
    input  logic                  req0_val,
    output logic                  req0_rdy,
    output logic [2*DATA_W-1:0]   resp0_msg_result,
    output logic                  resp0_val,
    input  logic                  resp0_rdy,

    input  logic                  req1_msg_fn,
    input  logic [DATA_W-1:0]     req1_msg_a,
    input  logic [DATA_W-1:0]     req1_msg_b,
    input  logic                  req1_val,
    output logic                  req1_rdy,
    output logic [2*DATA_W-1:0]   resp1_msg_result,
    output logic                  resp1_val,
    input  logic                  resp1_rdy,

    output logic                  divreq_msg_fn,
    output logic [DATA_W-1:0]     divreq_msg_a,
    output logic [DATA_W-1:0]     divreq_msg_b,
    output logic                  divreq_val,
    input  logic                  divreq_rdy,
    input  logic [2*DATA_W-1:0]   divresp_msg_result,
    input  logic                  divresp_val,
    output logic                  divresp_rdy,

    output logic                  busy
);

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic                  fn_q, fn_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic [1:0]            grant;

    imuldiv_rr_arb2 u_rr_arb2 (
        .req0_val   (req0_val),
        .req1_val   (req1_val),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= INIT_LAST;
            owner_q      <= OWNER_REQ0;
            fn_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            fn_q         <= fn_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        fn_d         = fn_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        req0_rdy     = 1'b0;
        req1_rdy     = 1'b0;
        divreq_val   = 1'b0;
        divresp_rdy  = 1'b0;
        resp0_val    = 1'b0;
        resp1_val    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req0_rdy = grant[0];
                req1_rdy = grant[1];
                if (req0_val && grant[0]) begin
                    fn_d         = req0_msg_fn;
                    a_d          = req0_msg_a;
                    b_d          = req0_msg_b;
                    owner_d      = OWNER_REQ0;
                    last_grant_d = OWNER_REQ0;
                    state_d      = ST_ISSUE;
                end else if (req1_val && grant[1]) begin
                    fn_d         = req1_msg_fn;
                    a_d          = req1_msg_a;
                    b_d          = req1_msg_b;
                    owner_d      = OWNER_REQ1;
                    last_grant_d = OWNER_REQ1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                divreq_val = 1'b1;
                if (divreq_rdy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                divresp_rdy = 1'b1;
                if (divresp_val) begin
                    result_d = divresp_msg_result;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                resp0_val = (owner_q == OWNER_REQ0);
                resp1_val = (owner_q == OWNER_REQ1);
                if ((owner_q == OWNER_REQ0 && resp0_rdy) ||
                    (owner_q == OWNER_REQ1 && resp1_rdy)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The state register already sits in IDLE during reset, but the
        // request grant is combinational from req*_val, so mask it here.
        if (reset) begin
            req0_rdy = 1'b0;
            req1_rdy = 1'b0;
        end
    end

    assign divreq_msg_fn    = fn_q;
    assign divreq_msg_a     = a_q;
    assign divreq_msg_b     = b_q;
    assign resp0_msg_result = result_q;
    assign resp1_msg_result = result_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: doc/imuldiv_div_share_arbiter.md
Name: imuldiv_div_share_arbiter

Overview:
Shares one iterative integer divide unit between two requesters (e.g. two pipeline issue ports) using val/rdy handshakes on all sides. It grants requesters round-robin, latches the winning request, and sequences the divider through issue, wait and response. It buffers the 64-bit result and returns it to the owning requester only. Only one transaction is in flight at a time, matching the iterative divider's single-operation capacity.

Parameters:
DATA_W, 32, operand width; result width is 2*DATA_W
INIT_LAST, 1, reset value of the last-grant pointer (1 means requester 0 wins the first tie)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req0_msg_fn  in  1  requester 0 function: 0 = div (signed), 1 = divu
req0_msg_a  in  DATA_W  requester 0 dividend
req0_msg_b  in  DATA_W  requester 0 divisor
req0_val  in  1  requester 0 request valid
req0_rdy  out  1  requester 0 request accepted
resp0_msg_result  out  2*DATA_W  requester 0 result, {rem, quot}
resp0_val  out  1  requester 0 response valid
resp0_rdy  in  1  requester 0 ready for response
req1_msg_fn, req1_msg_a, req1_msg_b, req1_val, req1_rdy, resp1_msg_result, resp1_val, resp1_rdy: same as port 0, for requester 1
divreq_msg_fn  out  1  to divider
divreq_msg_a  out  DATA_W  to divider
divreq_msg_b  out  DATA_W  to divider
divreq_val  out  1  to divider
divreq_rdy  in  1  from divider
divresp_msg_result  in  2*DATA_W  from divider
divresp_val  in  1  from divider
divresp_rdy  out  1  to divider
busy  out  1  high in any state other than IDLE

Behaviour:
Reset values:
- The FSM goes to IDLE and last_grant to INIT_LAST.
- The fn, a, b, owner and result registers clear to 0.
- All val/rdy outputs and busy are 0 while reset is high.

FSM states: IDLE, ISSUE, WAIT, RESP.

- IDLE
  - Grant rule: if only one reqN_val is high, that requester is granted. If both are high, the requester != last_grant is granted.
  - reqN_rdy = (state==IDLE) && granted==N. The other rdy is 0.
  - On a fire: latch fn/a/b and owner=N, set last_grant<=N, go to ISSUE.
- ISSUE
  - divreq_val=1 and divreq_msg_* = latched registers, held stable until accepted.
  - On divreq_rdy: go to WAIT.
- WAIT
  - divresp_rdy=1.
  - On divresp_val: latch divresp_msg_result and go to RESP.
- RESP
  - resp{owner}_val=1; the other respN_val=0.
  - respN_msg_result drives the result register on both ports. Only the owner's val qualifies it.
  - On resp{owner}_rdy: go to IDLE.

Timing and throughput:
- Accept at cycle t gives divreq_val at t+1.
- divresp_val at cycle d gives resp val at d+1.
- No bypass paths. Throughput is one transaction per (divider latency + 3) cycles minimum.

Boundary conditions:
- Both requesters continuously valid: grants alternate 0,1,0,1.
- An owner stalling in RESP blocks the other requester indefinitely. No timeout.
- divresp_val outside WAIT is ignored (divresp_rdy=0).
- divreq_rdy outside ISSUE is ignored.
- Requester val dropping in a non-IDLE state has no effect. Requests are only sampled in IDLE.
- A new request is never accepted in the same cycle a response completes (one IDLE bubble).
- Reset mid-transaction abandons it immediately. The divider shares the same reset, so no stale response follows.
- Result is passed through unmodified, bit-exact. The arbiter does no arithmetic.

Decomposition:
- Shared package: FSM state encoding (2 bits), owner encoding (REQ0=0, REQ1=1), fn encoding (DIV=0, DIVU=1).
- One natural sub-module: imuldiv_rr_arb2, a combinational 2-way round-robin grant. Inputs: two val bits and last_grant. Output: one-hot grant.
- The last_grant register stays in the parent.

Test Plan:
Test conditions: divider model with fixed 33-cycle latency, and responders always ready unless stated.
1. Single request: req0 div a=20 b=3 -> req0_rdy in the same cycle; divreq_val the next cycle; resp0_result={32'd2,32'd6} one cycle after divresp_val; resp1_val stays 0.
2. Tie after reset: both val; req0 divu 100/7, req1 div -9/2 -> req0 served first ({2,14}), then req1 ({-1,-4}); last_grant=1 at the end.
3. Fairness: both val held for 6 transactions -> owner sequence 0,1,0,1,0,1; each response goes to the correct port only.
4. Response backpressure: resp1_rdy=0 for 10 cycles in RESP -> resp1_val held with a stable result; req0_rdy=0 throughout; completes the cycle resp1_rdy rises.
5. Divider backpressure: divreq_rdy=0 for 5 cycles -> divreq_val and msg held stable; no requester rdy asserted.
6. Reset in WAIT: assert reset for 1 cycle -> busy=0 and all val/rdy=0 immediately; no resp_val afterwards; next req1 is accepted normally.
